// File: rtl/parallel_receiver.sv
// rtl/parallel_receiver.sv - serial-to-parallel receiver sampling a gated clock's falling edges
// Words are assembled MSB first and handed off through a valid/ack register with sticky overrun.
module parallel_receiver #(
    parameter int n = 9
) (
    input  logic       clk50,
    input  logic       rst,
    input  logic       enable,
    input  logic       gclk,
    input  logic       frame,
    input  logic       serial_in,
    input  logic       data_ack,
    input  logic       ovr_clr,
    output logic [n:0] dbus_out,
    output logic       data_valid,
    output logic       overrun,
    output logic       frame_err
);
    localparam int CW = $clog2(n + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(n + 1);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RECV = 1'b1;

    logic [2:0]    gs_q, gs_d;
    logic [1:0]    ds_q, ds_d;
    logic [1:0]    fs_q, fs_d;
    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic [n:0]    shreg_q, shreg_d;
    logic [n:0]    dbus_q, dbus_d;
    logic          done_q, done_d;
    logic          valid_q, valid_d;
    logic          ovr_q, ovr_d;
    logic          ferr_q, ferr_d;
    logic          sample;
    logic          frame_s;
    logic          bit_s;

    // Data and frame come from the stage aligned with gs2, i.e. the value seen as gclk fell.
    assign sample  = gs_q[2] & ~gs_q[1];
    assign frame_s = fs_q[1];
    assign bit_s   = ds_q[1];
    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        gs_d    = {gs_q[1:0], gclk};
        ds_d    = {ds_q[0], serial_in};
        fs_d    = {fs_q[0], frame};
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        dbus_d  = dbus_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;

        if (sample) begin
            if (frame_s) begin
                shreg_d = {shreg_q[n-1:0], bit_s};
                state_d = RECV;
                if (cnt_inc == CNT_FULL) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end else begin
                ferr_d  = (state_q == RECV) && (cnt_q != '0);
                state_d = IDLE;
                cnt_d   = '0;
                shreg_d = '0;
            end
        end

        // Overrun set below is ordered after the clear so that set wins.
        if (ovr_clr) begin
            ovr_d = 1'b0;
        end
        if (done_q) begin
            if (!valid_q || data_ack) begin
                dbus_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (data_ack) begin
            valid_d = 1'b0;
        end

        if (!enable) begin
            gs_d    = '0;
            ds_d    = '0;
            fs_d    = '0;
            state_d = IDLE;
            cnt_d   = '0;
            shreg_d = '0;
            dbus_d  = '0;
            valid_d = 1'b0;
            ovr_d   = 1'b0;
            done_d  = 1'b0;
            ferr_d  = 1'b0;
        end
    end

    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            gs_q    <= '0;
            ds_q    <= '0;
            fs_q    <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            dbus_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            gs_q    <= gs_d;
            ds_q    <= ds_d;
            fs_q    <= fs_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            dbus_q  <= dbus_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    assign dbus_out   = dbus_q;
    assign data_valid = valid_q;
    assign overrun    = ovr_q;
    assign frame_err  = ferr_q;

endmodule

// File: tb/tb_parallel_receiver.sv
// tb/tb_parallel_receiver.sv - scoreboard testbench for parallel_receiver
module tb_parallel_receiver;
    logic       clk50 = 1'b0;
    logic       rst, enable, gclk, frame, serial_in, data_ack, ovr_clr;
    logic [9:0] dbus_out;
    logic       data_valid, overrun, frame_err;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         ferr_cnt = 0;
    int         vrise_cnt = 0;
    logic       prev_valid = 1'b0;
    logic [9:0] exp_q[$];
    logic [9:0] exp_w;

    parallel_receiver #(.n(9)) dut (
        .clk50     (clk50),
        .rst       (rst),
        .enable    (enable),
        .gclk      (gclk),
        .frame     (frame),
        .serial_in (serial_in),
        .data_ack  (data_ack),
        .ovr_clr   (ovr_clr),
        .dbus_out  (dbus_out),
        .data_valid(data_valid),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    always #10 clk50 = ~clk50;

    // Each rising data_valid must deliver the oldest expected word.
    always @(negedge clk50) begin
        if (frame_err === 1'b1) ferr_cnt++;
        if (data_valid === 1'b1 && prev_valid === 1'b0) begin
            vrise_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL word_unexpected: got %h, required no word", dbus_out);
            end else begin
                exp_w = exp_q.pop_front();
                if (dbus_out !== exp_w) begin
                    n_fail++;
                    $display("FAIL word_value: got %h, required %h", dbus_out, exp_w);
                end
            end
        end
        prev_valid = data_valid;
    end

    task automatic gclk_period(input logic b, input logic fr);
        serial_in = b;
        frame     = fr;
        gclk      = 1'b1;
        repeat (3) @(negedge clk50);
        gclk = 1'b0;
        repeat (2) @(negedge clk50);
    endtask

    task automatic send_bits(input logic [9:0] w, input int nbits);
        for (int i = 9; i > 9 - nbits; i--) gclk_period(w[i], 1'b1);
    endtask

    task automatic idle(input int k);
        repeat (k) gclk_period(1'b0, 1'b0);
    endtask

    task automatic ack_word(output bit got);
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            if (data_valid === 1'b1) got = 1'b1;
            else @(negedge clk50);
        end
        if (got) begin
            data_ack = 1'b1;
            @(negedge clk50);
            data_ack = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; gclk = 1'b0; frame = 1'b0;
        serial_in = 1'b0; data_ack = 1'b0; ovr_clr = 1'b0;
        #1;
        n_checks++;
        if ({dbus_out, data_valid, overrun, frame_err} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, required 0", {dbus_out, data_valid, overrun, frame_err});
        end
        repeat (2) @(negedge clk50);
        rst = 1'b0;
        repeat (2) @(negedge clk50);
    endtask

    task automatic test_single_word();
        bit got;
        int f0;
        f0 = ferr_cnt;
        exp_q.push_back(10'h2A5);
        send_bits(10'h2A5, 10);
        idle(1);
        n_checks++;
        if (data_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b, required 1", data_valid); end
        n_checks++;
        if (dbus_out !== 10'h2A5) begin n_fail++; $display("FAIL single_dbus: got %h, required 2a5", dbus_out); end
        n_checks++;
        if (ferr_cnt != f0 || overrun !== 1'b0) begin
            n_fail++; $display("FAIL single_errs: got ferr %0d ovr %b, required 0 0", ferr_cnt - f0, overrun);
        end
        ack_word(got);
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL single_timeout: got no valid, required valid"); end
        n_checks++;
        if (data_valid !== 1'b0) begin n_fail++; $display("FAIL single_ack: got %b, required 0", data_valid); end
    endtask

    task automatic test_back_to_back();
        bit g1, g2;
        int f0;
        f0 = ferr_cnt;
        exp_q.push_back(10'h3FF);
        exp_q.push_back(10'h001);
        fork
            begin
                send_bits(10'h3FF, 10);
                send_bits(10'h001, 10);
                idle(2);
            end
            begin
                ack_word(g1);
                ack_word(g2);
            end
        join
        n_checks++;
        if (!(g1 && g2)) begin n_fail++; $display("FAIL b2b_timeout: got %b%b, required 11", g1, g2); end
        n_checks++;
        if (overrun !== 1'b0 || ferr_cnt != f0) begin
            n_fail++; $display("FAIL b2b_errs: got ovr %b ferr %0d, required 0 0", overrun, ferr_cnt - f0);
        end
    endtask

    task automatic test_frame_abort();
        bit got;
        int f0, v0;
        f0 = ferr_cnt;
        v0 = vrise_cnt;
        send_bits(10'h155, 6);
        idle(2);
        n_checks++;
        if (ferr_cnt - f0 != 1) begin n_fail++; $display("FAIL abort_ferr: got %0d pulses, required 1", ferr_cnt - f0); end
        n_checks++;
        if (data_valid !== 1'b0 || vrise_cnt != v0) begin
            n_fail++; $display("FAIL abort_valid: got %b, required 0", data_valid);
        end
        exp_q.push_back(10'h0F0);
        send_bits(10'h0F0, 10);
        idle(1);
        ack_word(got);
        n_checks++;
        if (!got || ferr_cnt - f0 != 1) begin
            n_fail++; $display("FAIL abort_next: got valid %b ferr %0d, required 1 1", got, ferr_cnt - f0);
        end
    endtask

    task automatic test_overrun();
        exp_q.push_back(10'h111);
        send_bits(10'h111, 10);
        send_bits(10'h222, 10);
        idle(1);
        n_checks++;
        if ({overrun, data_valid, dbus_out} !== {2'b11, 10'h111}) begin
            n_fail++; $display("FAIL ovr_set: got %b %b %h, required 1 1 111", overrun, data_valid, dbus_out);
        end
        ovr_clr = 1'b1;
        @(negedge clk50);
        ovr_clr = 1'b0;
        n_checks++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clr: got %b, required 0", overrun); end
        data_ack = 1'b1;
        @(negedge clk50);
        data_ack = 1'b0;
        n_checks++;
        if (data_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_ack: got %b, required 0", data_valid); end

        exp_q.push_back(10'h111);
        send_bits(10'h111, 10);
        idle(1);
        send_bits(10'h222, 9);
        serial_in = 1'b0; frame = 1'b1; gclk = 1'b1;
        repeat (3) @(negedge clk50);
        gclk = 1'b0;
        repeat (3) @(negedge clk50);
        data_ack = 1'b1;
        @(negedge clk50);
        data_ack = 1'b0;
        n_checks++;
        if ({overrun, data_valid, dbus_out} !== {2'b01, 10'h222}) begin
            n_fail++; $display("FAIL ack_on_done: got %b %b %h, required 0 1 222", overrun, data_valid, dbus_out);
        end
        idle(1);
        data_ack = 1'b1;
        @(negedge clk50);
        data_ack = 1'b0;
    endtask

    task automatic test_enable_rst();
        bit got;
        int f0;
        f0 = ferr_cnt;
        send_bits(10'h3C3, 4);
        enable = 1'b0;
        frame  = 1'b0;
        repeat (3) @(negedge clk50);
        enable = 1'b1;
        idle(2);
        n_checks++;
        if (ferr_cnt != f0) begin n_fail++; $display("FAIL enable_ferr: got %0d, required 0", ferr_cnt - f0); end
        exp_q.push_back(10'h2AA);
        send_bits(10'h2AA, 10);
        idle(1);
        ack_word(got);
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL enable_word: got no valid, required valid"); end

        exp_q.push_back(10'h3C3);
        send_bits(10'h3C3, 10);
        idle(1);
        send_bits(10'h1E1, 4);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({dbus_out, data_valid, overrun, frame_err} !== 13'h0) begin
            n_fail++; $display("FAIL rst_mid: got %h, required 0", {dbus_out, data_valid, overrun, frame_err});
        end
        @(negedge clk50);
        rst = 1'b0;
        frame = 1'b0;
        idle(2);
        exp_q.push_back(10'h1E1);
        send_bits(10'h1E1, 10);
        idle(1);
        ack_word(got);
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL rst_word: got no valid, required valid"); end
    endtask

    task automatic test_idle_glitch();
        int f0, v0;
        f0 = ferr_cnt;
        v0 = vrise_cnt;
        idle(30);
        n_checks++;
        if (vrise_cnt != v0 || ferr_cnt != f0 || data_valid !== 1'b0) begin
            n_fail++; $display("FAIL idle_quiet: got rises %0d ferr %0d, required 0 0", vrise_cnt - v0, ferr_cnt - f0);
        end
        gclk = 1'b1;
        repeat (2) @(negedge clk50);
        gclk = 1'b0;
        repeat (5) @(negedge clk50);
        idle(1);
        n_checks++;
        if (vrise_cnt != v0 || ferr_cnt != f0 || data_valid !== 1'b0) begin
            n_fail++; $display("FAIL glitch_quiet: got rises %0d ferr %0d, required 0 0", vrise_cnt - v0, ferr_cnt - f0);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_frame_abort();
        test_overrun();
        test_enable_rst();
        test_idle_glitch();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/parallel_receiver.md
Name: parallel_receiver

Overview:
- Serial-to-parallel receiver in the 50 MHz domain; the receive-side counterpart of the gated-clock serial transmitter.
- Samples a serial stream, MSB first, clocked by the 10 MHz gated clock gclk, framed by a level gate frame.
- Assembles n+1-bit words and presents each one on dbus_out with a valid/ack handshake.
- Sits between the Wallops gated-clock interface and the Ebox control logic.

Parameters:
n, 9, MSB index; word width is n+1 bits (default 10).

Ports:
clk50  input  1  50 MHz system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
enable  input  1  block enable; low = synchronous clear
gclk  input  1  10 MHz gated clock, asynchronous to clk50
frame  input  1  word gate, asynchronous; high for all n+1 bits of each word
serial_in  input  1  serial data, asynchronous; stable around gclk falling edge
data_ack  input  1  consumer ack, clk50 domain; clears data_valid
ovr_clr  input  1  clears overrun
dbus_out  output  n+1  received word, MSB = first bit received
data_valid  output  1  dbus_out holds an unacknowledged word
overrun  output  1  sticky: word dropped because previous word unacknowledged
frame_err  output  1  one-cycle pulse: word aborted by frame dropping mid-word

Behaviour:
- Reset (rst high, async): all outputs 0; state IDLE; bit count 0; shift register 0; synchronizer flops 0.
- enable low (sync): same clear as reset. Synchronizers hold 0, so no edge is detected on the first enabled cycles.
- Synchronization:
  - gclk passes through gs1→gs2→gs3. serial_in and frame each pass through two flops, aligned with gs2.
  - Sample event = gs3 & ~gs2 (gclk falling edge), at most one per gclk period.
  - Sampling on the falling edge reads mid-bit, because the transmitter updates data after the rising edge.
- State machine: IDLE, RECV.
  - IDLE: on a sample event with frame_s=1, shift in the bit, cnt=1, go to RECV. Sample events with frame_s=0 are ignored.
  - RECV, sample event with frame_s=1: shift left, new bit into LSB, cnt+1.
  - RECV, the event that makes cnt reach n+1: word complete, cnt=0.
    - If frame is still high at the next event, a new word starts there. Back-to-back words need no gap.
    - The state returns to IDLE only on an event with frame_s=0.
  - RECV, sample event with frame_s=0 and 0<cnt<n+1: abort. Discard the partial word, cnt=0, pulse frame_err for one clk50 cycle, go to IDLE.
- Word complete (registered on the completing clk50 edge):
  - data_valid=0, or data_ack=1 in the same cycle: load dbus_out, data_valid=1.
  - data_valid=1 and data_ack=0: keep the old word, drop the new word, set overrun.
- Handshake:
  - data_ack while data_valid=1 and no completion: data_valid=0 next cycle.
  - dbus_out holds its last value after ack and is only updated on a new load.
  - data_ack while data_valid=0: ignored.
- Overrun clears on ovr_clr, rst, or enable low. If an overrun set and ovr_clr occur in the same cycle, set wins.
- Latency: data_valid rises on the 3rd clk50 edge after the clk50 edge that first captures the final gclk fall into gs1.
- Counter: ceil(log2(n+2)) bits wide and never exceeds n+1.

Test Plan:
1. Single word 10'h2A5, frame high for 10 gclk periods → data_valid=1 after the 10th fall, dbus_out=10'h2A5, frame_err=0, overrun=0. Pulse data_ack → data_valid=0 next cycle.
2. Back-to-back 10'h3FF then 10'h001, frame high for 20 periods, ack after each word → two valid assertions with the correct values, no overrun, no frame_err.
3. Frame drops after 6 bits of 10'h155 → frame_err pulses once and data_valid stays 0. The following full word 10'h0F0 is received correctly.
4. Two words 10'h111, 10'h222 with no ack → dbus_out=10'h111, overrun=1. Then ovr_clr → overrun=0. Repeat with data_ack asserted on the completion cycle of word 2 → dbus_out=10'h222, data_valid=1, overrun=0.
5. enable low after 4 bits, then high, then send 10'h2AA → no stale bits, dbus_out=10'h2AA. Repeat with rst mid-word → all outputs 0 immediately, next word correct.
6. gclk toggling with frame=0 for 30 periods → no data_valid and no frame_err. A 2-cycle gclk high glitch with frame low → ignored.
